// File: rtl/wb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// wb_dmem_arbiter
//
// Two-master Wishbone-classic arbiter that shares the data-memory slave port
// between the core data port (m0) and the JTAG debug module (m1), so the
// debugger can reach dmem while the hart keeps running. A bus-hang watchdog
// returns err to the owning master when the slave never answers a strobe.
//
// Parameters
//   AW        address width (byte address)
//   DW        data width; byte-select width is DW/8
//   PRIORITY  0 = round-robin between masters, 1 = m1 (debug) fixed priority
//   TIMEOUT   cycles a strobe may wait for ack/err before the watchdog
//             answers with err; 0 removes the watchdog (8-bit counter, so
//             values above 256 are not meaningful)
//
// Ports
//   clk, reset_n               clock (rising edge), async active-low reset
//   mN_cyc_i/stb_i/we_i        master N cycle, strobe, write enable
//   mN_adr_i/dat_i/sel_i       master N address, write data, byte selects
//   mN_dat_o                   read data to master N (slave data broadcast)
//   mN_ack_o/err_o             ack / err to master N, only while N owns bus
//   s_cyc_o/stb_o/we_o         slave cycle, strobe, write enable
//   s_adr_o/dat_o/sel_o        slave address, write data, byte selects
//   s_dat_i, s_ack_i, s_err_i  slave read data, ack, error
//   grant_o                    one-hot owner {m1,m0}; 00 = idle
//   timeout_o                  one-cycle pulse when the watchdog fires
// ---------------------------------------------------------------------------
module wb_dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int PRIORITY = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // 1 when m1 was the most recent master granted; reset value makes m0 win
  // the very first tie.
  logic rr_last_m1;

  // Strobe actually presented to the slave. Gated by the owner's cyc so the
  // strobe and cycle drop together when the owner releases the bus.
  logic own_stb;
  logic wd_fire;

  // Read data goes to both masters; only the owner sees an ack alongside it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign own_stb = ((state_q == OWN0) && m0_cyc_i && m0_stb_i) ||
                   ((state_q == OWN1) && m1_cyc_i && m1_stb_i);
  assign s_stb_o = own_stb;

  assign grant_o   = {state_q == OWN1, state_q == OWN0};
  assign timeout_o = wd_fire;

  // State register and round-robin pointer. The pointer only moves when a
  // grant is issued out of IDLE, so it always names the last winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_last_m1 <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == OWN0) begin
        rr_last_m1 <= 1'b0;
      end else if (state_q == IDLE && state_d == OWN1) begin
        rr_last_m1 <= 1'b1;
      end
    end
  end

  // Arbitration and slave/master multiplexing. A grant is taken one edge
  // after the request, and an owner keeps the bus for its whole cycle so
  // multi-beat and read-modify-write sequences are never split. Leaving an
  // owner always passes through IDLE.
  always_comb begin
    state_d  = state_q;
    s_cyc_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (PRIORITY != 0) begin
            state_d = OWN1;
          end else if (rr_last_m1) begin
            state_d = OWN0;
          end else begin
            state_d = OWN1;
          end
        end else if (m0_cyc_i) begin
          state_d = OWN0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        s_cyc_o  = m0_cyc_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | wd_fire;
        if (!m0_cyc_i) begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        s_cyc_o  = m1_cyc_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | wd_fire;
        if (!m1_cyc_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

      logic [7:0] wd_count;
      logic       waiting;

      // A strobe is waiting while the slave gives neither ack nor err.
      assign waiting = own_stb && !s_ack_i && !s_err_i;
      assign wd_fire = waiting && (wd_count == WD_LAST);

      // Counts consecutive unanswered strobe cycles. After firing it starts
      // over, so a master that keeps its strobe up gets a fresh err every
      // TIMEOUT cycles instead of a stuck error line.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          wd_count <= '0;
        end else if (!waiting || wd_fire || (state_d != state_q)) begin
          wd_count <= '0;
        end else begin
          wd_count <= wd_count + 8'd1;
        end
      end
    end else begin : g_no_wd
      assign wd_fire = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_dmem_arbiter
//
// Two arbiter instances share every input: dut_a is round-robin, dut_b has
// fixed debug priority; both use an 8-cycle watchdog. Directed scenarios
// cover reset, a single write, round-robin alternation, priority hold-off,
// watchdog timeout and slave error; a random run compares both instances
// against a behavioural owner/wait-count model every cycle.
// ---------------------------------------------------------------------------
module tb_wb_dmem_arbiter;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i;

  logic [31:0] a_m0_dat_o, a_m1_dat_o, a_s_adr_o, a_s_dat_o;
  logic        a_m0_ack_o, a_m0_err_o, a_m1_ack_o, a_m1_err_o;
  logic        a_s_cyc_o, a_s_stb_o, a_s_we_o, a_timeout_o;
  logic [3:0]  a_s_sel_o;
  logic [1:0]  a_grant_o;

  logic [31:0] b_m0_dat_o, b_m1_dat_o, b_s_adr_o, b_s_dat_o;
  logic        b_m0_ack_o, b_m0_err_o, b_m1_ack_o, b_m1_err_o;
  logic        b_s_cyc_o, b_s_stb_o, b_s_we_o, b_timeout_o;
  logic [3:0]  b_s_sel_o;
  logic [1:0]  b_grant_o;

  int total = 0;
  int bad   = 0;

  wb_dmem_arbiter #(.AW(32), .DW(32), .PRIORITY(0), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(a_m0_dat_o), .m0_ack_o(a_m0_ack_o), .m0_err_o(a_m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(a_m1_dat_o), .m1_ack_o(a_m1_ack_o), .m1_err_o(a_m1_err_o),
    .s_cyc_o(a_s_cyc_o), .s_stb_o(a_s_stb_o), .s_we_o(a_s_we_o),
    .s_adr_o(a_s_adr_o), .s_dat_o(a_s_dat_o), .s_sel_o(a_s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(a_grant_o), .timeout_o(a_timeout_o)
  );

  wb_dmem_arbiter #(.AW(32), .DW(32), .PRIORITY(1), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(b_m0_dat_o), .m0_ack_o(b_m0_ack_o), .m0_err_o(b_m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(b_m1_dat_o), .m1_ack_o(b_m1_ack_o), .m1_err_o(b_m1_err_o),
    .s_cyc_o(b_s_cyc_o), .s_stb_o(b_s_stb_o), .s_we_o(b_s_we_o),
    .s_adr_o(b_s_adr_o), .s_dat_o(b_s_dat_o), .s_sel_o(b_s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(b_grant_o), .timeout_o(b_timeout_o)
  );

  // Every output of each instance packed in a fixed order for the random run.
  logic [141:0] obs_a, obs_b;
  assign obs_a = {a_grant_o, a_s_cyc_o, a_s_stb_o, a_s_we_o, a_s_adr_o, a_s_dat_o,
                  a_s_sel_o, a_m0_ack_o, a_m0_err_o, a_m1_ack_o, a_m1_err_o,
                  a_timeout_o, a_m0_dat_o, a_m1_dat_o};
  assign obs_b = {b_grant_o, b_s_cyc_o, b_s_stb_o, b_s_we_o, b_s_adr_o, b_s_dat_o,
                  b_s_sel_o, b_m0_ack_o, b_m0_err_o, b_m1_ack_o, b_m1_err_o,
                  b_timeout_o, b_m0_dat_o, b_m1_dat_o};

  // Reference model state per instance: owner (-1 idle), last winner and
  // number of consecutive unanswered strobe cycles.
  int own[2];
  int last[2];
  int wd[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
    m0_adr_i = '0;   m0_dat_i = '0;   m0_sel_i = '0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    m1_adr_i = '0;   m1_dat_i = '0;   m1_sel_i = '0;
    s_dat_i  = '0;   s_ack_i  = 1'b0; s_err_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] got9;
    logic [4:0] got5;
    idle_inputs();
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    got9 = {a_grant_o, b_grant_o, a_s_cyc_o, a_s_stb_o, a_m0_ack_o, a_m1_err_o, a_timeout_o};
    total++;
    if (got9 !== 9'b0) begin
      bad++;
      $display("[TB] FAIL reset_idle: got %b want 000000000", got9);
    end
    tick();
    reset_n  = 1'b1;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
    m0_adr_i = 32'h40; m0_dat_i = 32'h1234_5678; m0_sel_i = 4'hF;
    @(negedge clk);
    total++;
    if ({a_grant_o, a_s_cyc_o} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_req_cycle: got %b want 000", {a_grant_o, a_s_cyc_o});
    end
    tick();
    @(negedge clk);
    total++;
    if ({a_grant_o, a_s_cyc_o} !== 3'b011) begin
      bad++;
      $display("[TB] FAIL reset_first_grant: got %b want 011", {a_grant_o, a_s_cyc_o});
    end
    #2;
    reset_n = 1'b0;
    s_ack_i = 1'b1;
    #1;
    got5 = {a_grant_o, a_s_cyc_o, a_s_stb_o, a_m0_ack_o};
    total++;
    if (got5 !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_midxfer: got %b want 00000", got5);
    end
    tick();
    s_ack_i = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (a_grant_o !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_release_lat: got %b want 00", a_grant_o);
    end
    tick();
    @(negedge clk);
    total++;
    if (a_grant_o !== 2'b01) begin
      bad++;
      $display("[TB] FAIL reset_regrant: got %b want 01", a_grant_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_single_write();
    logic [72:0] want_bus;
    logic [1:0]  want_ack;
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
    m0_adr_i = 32'h100; m0_dat_i = 32'hDEAD_BEEF; m0_sel_i = 4'hF;
    m1_adr_i = 32'hAAAA_0000; m1_dat_i = 32'h5555_5555; m1_sel_i = 4'h3;
    @(negedge clk);
    total++;
    if ({a_grant_o, a_s_cyc_o} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL write_req_cycle: got %b want 000", {a_grant_o, a_s_cyc_o});
    end
    want_bus = {1'b1, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF};
    for (int w = 0; w < 3; w++) begin
      tick();
      s_ack_i = (w == 2);
      want_ack = {(w == 2), 1'b0};
      @(negedge clk);
      total++;
      if ({a_s_cyc_o, a_s_stb_o, a_s_we_o, a_s_adr_o, a_s_dat_o, a_s_sel_o} !== want_bus) begin
        bad++;
        $display("[TB] FAIL write_bus_%0d: got %h want %h", w,
                 {a_s_cyc_o, a_s_stb_o, a_s_we_o, a_s_adr_o, a_s_dat_o, a_s_sel_o}, want_bus);
      end
      total++;
      if ({a_m0_ack_o, a_m1_ack_o} !== want_ack) begin
        bad++;
        $display("[TB] FAIL write_ack_%0d: got %b want %b", w, {a_m0_ack_o, a_m1_ack_o}, want_ack);
      end
    end
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
    @(negedge clk);
    total++;
    if ({a_grant_o, a_s_cyc_o} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL write_cyc_drop: got %b want 010", {a_grant_o, a_s_cyc_o});
    end
    tick();
    @(negedge clk);
    total++;
    if (a_grant_o !== 2'b00) begin
      bad++;
      $display("[TB] FAIL write_release: got %b want 00", a_grant_o);
    end
    idle_inputs();
  endtask

  // Both masters keep requesting; each takes one acked beat and drops cyc for
  // a cycle. The distinct grant values seen must alternate through idle.
  task automatic test_round_robin();
    int         done0, done1;
    logic       got0, got1;
    logic [1:0] prev, want;
    logic [1:0] seq[$];
    do_reset();
    done0 = 0; done1 = 0; got0 = 1'b0; got1 = 1'b0; prev = 2'b11;
    for (int c = 0; c < 40; c++) begin
      m0_cyc_i = (done0 < 4) && !got0; m0_stb_i = m0_cyc_i; m0_adr_i = 32'h1000 + c;
      m1_cyc_i = (done1 < 4) && !got1; m1_stb_i = m1_cyc_i; m1_adr_i = 32'h2000 + c;
      #1;
      s_ack_i = a_s_stb_o;
      @(negedge clk);
      if (a_grant_o !== prev) begin
        seq.push_back(a_grant_o);
        prev = a_grant_o;
      end
      got0 = a_m0_ack_o;
      got1 = a_m1_ack_o;
      if (got0) done0++;
      if (got1) done1++;
      tick();
    end
    total++;
    if (seq.size() != 17) begin
      bad++;
      $display("[TB] FAIL rr_seq_len: got %0d want 17", seq.size());
    end
    for (int i = 0; i < 17; i++) begin
      if (i % 2 == 0) want = 2'b00;
      else            want = (((i - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10;
      if (i < seq.size()) begin
        total++;
        if (seq[i] !== want) begin
          bad++;
          $display("[TB] FAIL rr_seq_%0d: got %b want %b", i, seq[i], want);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  // m0 holds a 3-beat cycle on the fixed-priority instance while m1 asks
  // from beat 1; m1 must wait until m0 releases, then one idle cycle.
  task automatic test_priority();
    logic [36:0] got, want;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      m0_cyc_i = (c < 4); m0_stb_i = (c < 4); m0_adr_i = 32'h300;
      m1_cyc_i = (c >= 1); m1_stb_i = (c >= 1); m1_adr_i = 32'h400;
      s_ack_i  = (c >= 1 && c <= 3);
      case (c)
        0:       want = {2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
        1, 2, 3: want = {2'b01, 1'b1, 1'b1, 1'b0, 32'h300};
        4:       want = {2'b01, 1'b0, 1'b0, 1'b0, 32'h300};
        5:       want = {2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
        default: want = {2'b10, 1'b1, 1'b0, 1'b0, 32'h400};
      endcase
      @(negedge clk);
      got = {b_grant_o, b_s_cyc_o, b_m0_ack_o, b_m1_ack_o, b_s_adr_o};
      total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL prio_cycle_%0d: got %h want %h", c, got, want);
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_timeout();
    logic [4:0] got, want;
    logic       fire;
    do_reset();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_adr_i = 32'h200;
    for (int k = 1; k <= 17; k++) begin
      tick();
      @(negedge clk);
      fire = (k % TMO == 0);
      want = {fire, fire, 1'b0, 1'b1, fire};
      got  = {a_m1_err_o, a_timeout_o, a_m0_err_o, a_s_stb_o, b_timeout_o};
      total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL timeout_strobe_%0d: got %b want %b", k, got, want);
      end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  // Slave err on beat 2 must reach m0 and restart the wait count: the next
  // watchdog err comes a full TMO cycles after the slave err.
  task automatic test_slave_err();
    logic [2:0] got, want;
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 32'hFFFF_0000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      s_err_i = (k == 2);
      want = {(k == 2) || (k == 10), (k == 10), 1'b0};
      @(negedge clk);
      got = {a_m0_err_o, a_timeout_o, a_m1_err_o};
      total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL slave_err_%0d: got %b want %b", k, got, want);
      end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  // Expected outputs of one instance from the owner and wait count.
  task automatic model_out(input int p, output logic [141:0] v, output logic waiting,
                           output logic fire);
    logic [1:0]  g;
    logic        cyc, stb, we, a0, e0, a1, e1;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    g = 2'b00; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
    a0 = 1'b0; e0 = 1'b0; a1 = 1'b0; e1 = 1'b0;
    if (own[p] == 0) begin
      g = 2'b01; cyc = m0_cyc_i; stb = m0_cyc_i && m0_stb_i; we = m0_we_i;
      adr = m0_adr_i; dat = m0_dat_i; sel = m0_sel_i;
    end else if (own[p] == 1) begin
      g = 2'b10; cyc = m1_cyc_i; stb = m1_cyc_i && m1_stb_i; we = m1_we_i;
      adr = m1_adr_i; dat = m1_dat_i; sel = m1_sel_i;
    end
    waiting = stb && !s_ack_i && !s_err_i;
    fire    = waiting && (wd[p] == TMO - 1);
    if (own[p] == 0) begin
      a0 = s_ack_i; e0 = s_err_i || fire;
    end else if (own[p] == 1) begin
      a1 = s_ack_i; e1 = s_err_i || fire;
    end
    v = {g, cyc, stb, we, adr, dat, sel, a0, e0, a1, e1, fire, s_dat_i, s_dat_i};
  endtask

  task automatic model_step(input int p, input int prio, input logic waiting, input logic fire);
    int nxt;
    if (own[p] < 0) begin
      if (m0_cyc_i && m1_cyc_i) nxt = (prio != 0) ? 1 : ((last[p] == 1) ? 0 : 1);
      else if (m0_cyc_i)        nxt = 0;
      else if (m1_cyc_i)        nxt = 1;
      else                      nxt = -1;
      if (nxt >= 0) last[p] = nxt;
      own[p] = nxt;
      wd[p]  = 0;
    end else if (!((own[p] == 0) ? m0_cyc_i : m1_cyc_i)) begin
      own[p] = -1;
      wd[p]  = 0;
    end else begin
      wd[p] = (waiting && !fire) ? wd[p] + 1 : 0;
    end
  endtask

  task automatic test_random();
    logic [141:0] exp_a, exp_b;
    logic         wa, fa, wb, fb;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      own[p] = -1; last[p] = 1; wd[p] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(0, 5) == 0) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i = m0_cyc_i && ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i && ($urandom_range(0, 3) != 0);
      m0_we_i  = 1'($urandom_range(0, 1));
      m1_we_i  = 1'($urandom_range(0, 1));
      m0_adr_i = $urandom; m0_dat_i = $urandom; m0_sel_i = 4'($urandom_range(0, 15));
      m1_adr_i = $urandom; m1_dat_i = $urandom; m1_sel_i = 4'($urandom_range(0, 15));
      s_dat_i  = $urandom;
      s_ack_i  = ($urandom_range(0, 4) == 0);
      s_err_i  = ($urandom_range(0, 19) == 0);
      model_out(0, exp_a, wa, fa);
      model_out(1, exp_b, wb, fb);
      @(negedge clk);
      total++;
      if (obs_a !== exp_a) begin
        bad++;
        $display("[TB] FAIL rand_rr_%0d: got %h want %h", c, obs_a, exp_a);
      end
      total++;
      if (obs_b !== exp_b) begin
        bad++;
        $display("[TB] FAIL rand_prio_%0d: got %h want %h", c, obs_b, exp_b);
      end
      model_step(0, 0, wa, fa);
      model_step(1, 1, wb, fb);
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_time_limit: simulation did not finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_priority();
    test_timeout();
    test_slave_err();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
